// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port unified-memory arbiter.
package mem_arb_pkg;

   localparam int unsigned CNT_W = 4;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_EXT = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the port
// that was not granted last.
module mem_arb_rr2
   import mem_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_gnt,
   output logic [1:0] gnt,
   output logic       gnt_idx
);

   always_comb begin
      gnt_idx = PORT_CPU;
      gnt     = 2'b00;
      case (valid)
         2'b01:   gnt_idx = PORT_CPU;
         2'b10:   gnt_idx = PORT_EXT;
         2'b11:   gnt_idx = ~last_gnt;
         default: gnt_idx = PORT_CPU;
      endcase
      if (valid != 2'b00)
         gnt = gnt_idx ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified MIPS memory between the CPU and an external master,
// sequencing one fixed-latency access at a time.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

   arb_state_t        state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              last_gnt;
   logic              owner;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [1:0]        gnt;
   logic              gnt_idx;
   logic              accept;
   logic              capture;

   mem_arb_rr2 u_rr (
      .valid    ({req1_valid, req0_valid}),
      .last_gnt (last_gnt),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and decoded outputs; ready is gated so reset shows no accept
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      capture    = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if ((gnt != 2'b00) && !reset) begin
               accept     = 1'b1;
               req0_ready = gnt[0];
               req1_ready = gnt[1];
               state_nxt  = ACCESS;
            end
         end
         ACCESS: begin
            busy      = 1'b1;
            mem_en    = 1'b1;
            mem_we    = lat_we;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            if (cnt == '0) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            rsp0_valid = (owner == PORT_CPU);
            rsp1_valid = (owner == PORT_EXT);
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, latency counter and response data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         last_gnt  <= PORT_EXT;
         owner     <= PORT_CPU;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rsp_rdata <= '0;
      end else begin
         if (accept) begin
            owner     <= gnt_idx;
            last_gnt  <= gnt_idx;
            lat_we    <= gnt_idx ? req1_we    : req0_we;
            lat_addr  <= gnt_idx ? req1_addr  : req0_addr;
            lat_wdata <= gnt_idx ? req1_wdata : req0_wdata;
            cnt       <= CNT_INIT;
         end else if ((state == ACCESS) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (capture)
            rsp_rdata <= lat_we ? '0 : mem_rdata;
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters.
  - Port 0: the CPU memory interface (fetch, lw, sw).
  - Port 1: an external loader/debug master.
- Sits between the CPU's iord-selected address path and the memory macro.
- Sequences each access over a fixed-latency memory and returns the response to the owning port.
- Round-robin arbitration; the CPU stalls by holding its request valid until it is accepted.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, memory access cycles per transfer; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  CPU request pending
- req0_we  in  1  CPU write (1) / read (0)
- req0_addr  in  ADDR_W  CPU address
- req0_wdata  in  DATA_W  CPU write data
- req0_ready  out  1  one-cycle accept pulse for port 0
- rsp0_valid  out  1  one-cycle completion pulse for port 0
- req1_valid, req1_we, req1_addr, req1_wdata  in  1/1/ADDR_W/DATA_W  same as port 0, external master
- req1_ready  out  1  accept pulse for port 1
- rsp1_valid  out  1  completion pulse for port 1
- rsp_rdata  out  DATA_W  read data, valid with rspX_valid
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid on the last ACCESS cycle
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset:
  - state=IDLE, last_gnt=1, all outputs and latched request registers 0.
  - Reset mid-transfer drops the access; no rsp pulse is issued for it.
- IDLE:
  - If no valid: stay; all outputs 0.
  - If exactly one reqX_valid: grant port X.
  - If both valid: grant the port != last_gnt.
  - On grant (same cycle):
    - reqX_ready=1 (combinational from valids and last_gnt).
    - Latch owner, we, addr, wdata; last_gnt<=owner; cnt<=MEM_LAT-1; next state ACCESS.
- ACCESS:
  - mem_en=1; mem_we=latched we; mem_addr/mem_wdata driven from latched registers, stable for the whole state.
  - cnt decrements each cycle.
  - When cnt==0: capture mem_rdata into rsp_rdata (capture 0 for writes); next state DONE.
- DONE:
  - rsp<owner>_valid=1 for exactly one cycle; rsp_rdata held.
  - mem_en=0, mem_we=0. Next state IDLE.
  - No acceptance in DONE.
- rsp_rdata holds its value until the next capture.
- Latency: accept at cycle t; mem_en at t+1..t+MEM_LAT; rsp at t+MEM_LAT+1. Next accept no earlier than t+MEM_LAT+2.
- Requesters must hold valid/we/addr/wdata stable until ready. Inputs are ignored outside IDLE.
- A valid dropped before ready is legal; nothing is recorded.
- Never more than one ready or one rsp pulse per cycle; ready0 and ready1 are mutually exclusive.
- cnt is 4 bits wide; MEM_LAT=1 means a single ACCESS cycle.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t.
  - Constants PORT_CPU=0, PORT_EXT=1.
- One sub-module, mem_arb_rr2: purely combinational two-way round-robin picker.
  - Inputs: valid[1:0], last_gnt. Outputs: gnt[1:0], gnt_idx.
  - last_gnt remains registered in the parent.

Test Plan:
- Reset with both valids high -> all outputs 0, busy=0. On release, ready0 pulses first (last_gnt resets to 1).
- Port 0 read addr 0x10, memory model returns 0xDEADBEEF, MEM_LAT=2:
  - ready0 at t; mem_en=1, mem_we=0, mem_addr=0x10 at t+1..t+2.
  - rsp0_valid=1 with rsp_rdata=0xDEADBEEF at t+3; busy=0 at t+4.
- Port 1 write addr 0x20, data 0x00001234:
  - mem_we=1, mem_wdata=0x1234 at t+1..t+2.
  - rsp1_valid at t+3, rsp_rdata=0, rsp0_valid stays 0.
- Both ports valid continuously for 4 transfers -> grant order 0,1,0,1; accepts at t, t+4, t+8, t+12; never concurrent ready.
- reset pulsed at t+1 during a port 0 read -> outputs 0 next cycle, no rsp0_valid. A following port 1 read completes normally at accept+3.
- MEM_LAT=1 build, port 0 read -> mem_en for exactly 1 cycle, rsp0_valid at t+2, back-to-back accept at t+3.
